// File: rtl/lsu_sb.sv
// Load-store unit with a posted store buffer in front of one Wishbone classic master port.
// Stores retire once buffered; loads wait for the buffer to drain so program order holds.
module lsu_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                valid_o,
  output logic                err_o,
  output logic                st_err_o,
  output logic                sb_empty_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LD_BUS, ST_BUS, LD_RESP} state_t;
  state_t state, nxt;

  // request decode
  logic [OFF_W-1:0]  off;
  logic              misal;
  logic [NB-1:0]     smask, sel;
  logic [DATA_W-1:0] wdat;
  logic [ADDR_W-1:0] aadr;

  assign off  = addr_i[OFF_W-1:0];
  assign sel  = smask << off;
  assign wdat = data_i << {off, 3'b000};
  assign aadr = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    case (size_i)
      2'b00:   begin misal = 1'b0;             smask = NB'(1);   end
      2'b01:   begin misal = addr_i[0];        smask = NB'(3);   end
      2'b10:   begin misal = |addr_i[1:0];     smask = NB'(15);  end
      default: begin misal = (DATA_W != 64) || (|addr_i[2:0]); smask = NB'(255); end
    endcase
  end

  // store buffer: extra pointer MSB tells full from empty
  logic [ADDR_W-1:0] sb_adr [SB_DEPTH];
  logic [NB-1:0]     sb_sel [SB_DEPTH];
  logic [DATA_W-1:0] sb_dat [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  rd_idx;
  logic              empty, full;

  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                  (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // acceptance; valid_o high blocks re-accepting the still-held request
  logic valid_q, err_q, st_err_q;
  logic idle_req, mis_acc, st_acc, ld_acc;

  assign idle_req = req_i & ~valid_q;
  assign mis_acc  = idle_req & misal;
  assign st_acc   = idle_req & ~misal & we_i & ~full;
  assign ld_acc   = idle_req & ~misal & ~we_i & (state == IDLE) & empty;

  // bus termination
  logic [TMO_W-1:0] tmo;
  logic bus, tmo_hit, term, berr, ld_done, pop;

  assign bus     = (state == LD_BUS) || (state == ST_BUS);
  assign tmo_hit = (tmo == TMO_W'(TIMEOUT - 1));
  assign term    = bus & (wb_ack_i | wb_err_i | tmo_hit);
  assign berr    = wb_err_i | (tmo_hit & ~wb_ack_i);
  assign ld_done = (state == LD_BUS) & term;
  assign pop     = (state == ST_BUS) & term;

  // captured load request
  logic [ADDR_W-1:0] ld_adr;
  logic [NB-1:0]     ld_sel;
  logic [OFF_W-1:0]  ld_off;
  logic [1:0]        ld_size;
  logic              ld_uns;

  logic [DATA_W-1:0] sh, ld_val;
  int                nbits;
  logic              fill;

  always_comb begin
    sh = wb_dat_i >> {ld_off, 3'b000};
    case (ld_size)
      2'b00:   begin nbits = 8;      fill = sh[7];        end
      2'b01:   begin nbits = 16;     fill = sh[15];       end
      2'b10:   begin nbits = 32;     fill = sh[31];       end
      default: begin nbits = DATA_W; fill = sh[DATA_W-1]; end
    endcase
    fill = fill & ~ld_uns;
    for (int i = 0; i < DATA_W; i++) ld_val[i] = (i < nbits) ? sh[i] : fill;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!empty) nxt = ST_BUS;
               else if (ld_acc) nxt = LD_BUS;
      LD_BUS:  if (term) nxt = LD_RESP;
      ST_BUS:  if (term) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tmo      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      st_err_q <= 1'b0;
      data_o   <= '0;
      ld_adr   <= '0;
      ld_sel   <= '0;
      ld_off   <= '0;
      ld_size  <= '0;
      ld_uns   <= 1'b0;
    end else begin
      state    <= nxt;
      tmo      <= (bus & ~term) ? tmo + 1'b1 : '0;
      valid_q  <= mis_acc | st_acc | ld_done;
      err_q    <= mis_acc | (ld_done & berr);
      st_err_q <= pop & berr;
      if (st_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (ld_done)               data_o <= berr ? '0 : ld_val;
      else if (mis_acc | st_acc) data_o <= '0;
      if (ld_acc) begin
        ld_adr  <= aadr;
        ld_sel  <= sel;
        ld_off  <= off;
        ld_size <= size_i;
        ld_uns  <= unsigned_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_adr[wr_ptr[IDX_W-1:0]] <= aadr;
      sb_sel[wr_ptr[IDX_W-1:0]] <= sel;
      sb_dat[wr_ptr[IDX_W-1:0]] <= wdat;
    end
  end

  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign st_err_o   = st_err_q;
  assign sb_empty_o = empty & (state != ST_BUS);
  assign wb_cyc_o   = bus;
  assign wb_stb_o   = bus;
  assign wb_we_o    = (state == ST_BUS);

  always_comb begin
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    if (state == ST_BUS) begin
      wb_adr_o = sb_adr[rd_idx];
      wb_sel_o = sb_sel[rd_idx];
      wb_dat_o = sb_dat[rd_idx];
    end else if (state == LD_BUS) begin
      wb_adr_o = ld_adr;
      wb_sel_o = ld_sel;
    end
  end
endmodule

// File: tb/tb_lsu_sb.sv
// Directed bench for lsu_sb: vector table for single accesses plus sequences for
// buffer-full stall, load timeout and reset during a store drain.
module tb_lsu_sb;
  localparam int DW = 32, AW = 32, DEP = 4, TMO = 32;

  logic          clk = 1'b0, rst_i = 1'b1;
  logic          req_i = 0, we_i = 0, unsigned_i = 0;
  logic [1:0]    size_i = 0;
  logic [AW-1:0] addr_i = 0;
  logic [DW-1:0] data_i = 0, data_o;
  logic          valid_o, err_o, st_err_o, sb_empty_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i = 0;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic          wb_ack_i = 0, wb_err_i = 0;

  lsu_sb #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .valid_o(valid_o), .err_o(err_o), .st_err_o(st_err_o), .sb_empty_o(sb_empty_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit stb_bad = 0;
  always @(negedge clk) if (wb_stb_o !== wb_cyc_o) stb_bad = 1;

  // rsp: 0 ack, 1 err, 2 ack+err; dly 0 = never respond
  typedef struct {
    logic we; logic [1:0] size; logic uns;
    logic [31:0] addr, wdata, rdat;
    int dly, rsp; bit nodrain; int pre; logic [3:0] pre_sel; bit bus;
    logic exp_err; logic [31:0] exp_data; logic [3:0] exp_sel;
    logic [31:0] exp_wdat; int exp_sterr; logic [31:0] exp_adr;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
      logic [31:0] wdata, logic [31:0] rdat, int dly, int rsp, bit nodrain, int pre,
      logic [3:0] pre_sel, bit bus, logic exp_err, logic [31:0] exp_data,
      logic [3:0] exp_sel, logic [31:0] exp_wdat, int exp_sterr, logic [31:0] exp_adr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdat = rdat;
    v.dly = dly; v.rsp = rsp; v.nodrain = nodrain; v.pre = pre; v.pre_sel = pre_sel;
    v.bus = bus; v.exp_err = exp_err; v.exp_data = exp_data; v.exp_sel = exp_sel;
    v.exp_wdat = exp_wdat; v.exp_sterr = exp_sterr; v.exp_adr = exp_adr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got = 0, saw = 0, is_pre = 0, prev_cyc = 0, done = 0;
    int npre = 0, tcnt = 0, sterr = 0;
    req_i = 1; we_i = v.we; size_i = v.size; unsigned_i = v.uns;
    addr_i = v.addr; data_i = v.wdata;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      wb_ack_i = 0; wb_err_i = 0;
      if (st_err_o) sterr++;
      if (valid_o && !got) begin
        got = 1;
        chk($sformatf("v%0d_err", idx), err_o, v.exp_err);
        if (!v.we && v.bus) chk($sformatf("v%0d_data", idx), data_o, v.exp_data);
        req_i = 0;
      end
      if (wb_cyc_o) begin
        if (!prev_cyc) begin
          tcnt = 0;
          is_pre = (wb_we_o !== v.we);
          if (is_pre) begin
            npre++;
            chk($sformatf("v%0d_pre_sel", idx), wb_sel_o, v.pre_sel);
          end else begin
            saw = 1;
            chk($sformatf("v%0d_adr", idx), wb_adr_o, v.exp_adr);
            chk($sformatf("v%0d_sel", idx), wb_sel_o, v.exp_sel);
            if (v.we) chk($sformatf("v%0d_wdat", idx), wb_dat_o, v.exp_wdat);
          end
        end
        tcnt++;
        if (is_pre) begin
          if (tcnt == 1) wb_ack_i = 1;
        end else if (v.dly != 0 && tcnt == v.dly) begin
          wb_ack_i = (v.rsp != 1);
          wb_err_i = (v.rsp != 0);
          wb_dat_i = v.rdat;
        end
      end
      prev_cyc = wb_cyc_o;
      done = got && (v.nodrain || (sb_empty_o && !wb_cyc_o));
    end
    wb_ack_i = 0; wb_err_i = 0;
    chk($sformatf("v%0d_completed", idx), done, 1);
    chk($sformatf("v%0d_pre_count", idx), npre, v.pre);
    chk($sformatf("v%0d_bus_seen", idx), saw, v.bus);
    chk($sformatf("v%0d_st_err", idx), sterr, v.exp_sterr);
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input string name);
    bit got = 0;
    req_i = 1; we_i = 1; size_i = 2'b10; unsigned_i = 0; addr_i = a; data_i = d;
    for (int c = 0; c < 4 && !got; c++) begin
      tick();
      if (valid_o) got = 1;
    end
    req_i = 0;
    chk(name, got, 1);
  endtask

  vec_t tbl[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          we sz u  addr          wdata         rdat          dly rsp nd pre psel bus err data          sel   wdat          ste adr
    tbl[0]  = mk(1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        3, 0, 0, 0, 4'h0, 1, 0, 32'h0,        4'hF, 32'hDEADBEEF, 0, 32'h100);
    tbl[1]  = mk(1, 0, 0, 32'h101, 32'h000000CD, 32'h0,        1, 0, 0, 0, 4'h0, 1, 0, 32'h0,        4'h2, 32'h0000CD00, 0, 32'h100);
    tbl[2]  = mk(1, 0, 0, 32'h103, 32'h000000AB, 32'h0,        1, 0, 1, 0, 4'h0, 0, 0, 32'h0,        4'h8, 32'hAB000000, 0, 32'h100);
    tbl[3]  = mk(0, 0, 0, 32'h103, 32'h0,        32'hAB000000, 1, 0, 0, 1, 4'h8, 1, 0, 32'hFFFFFFAB, 4'h8, 32'h0,        0, 32'h100);
    tbl[4]  = mk(0, 0, 1, 32'h103, 32'h0,        32'hAB000000, 1, 0, 0, 0, 4'h0, 1, 0, 32'h000000AB, 4'h8, 32'h0,        0, 32'h100);
    tbl[5]  = mk(0, 1, 0, 32'h102, 32'h0,        32'h80017777, 2, 0, 0, 0, 4'h0, 1, 0, 32'hFFFF8001, 4'hC, 32'h0,        0, 32'h100);
    tbl[6]  = mk(0, 1, 1, 32'h100, 32'h0,        32'h12348765, 1, 0, 0, 0, 4'h0, 1, 0, 32'h00008765, 4'h3, 32'h0,        0, 32'h100);
    tbl[7]  = mk(0, 2, 0, 32'h104, 32'h0,        32'hCAFEF00D, 4, 0, 0, 0, 4'h0, 1, 0, 32'hCAFEF00D, 4'hF, 32'h0,        0, 32'h104);
    tbl[8]  = mk(1, 1, 0, 32'h106, 32'h0000BEEF, 32'h0,        1, 0, 0, 0, 4'h0, 1, 0, 32'h0,        4'hC, 32'hBEEF0000, 0, 32'h104);
    tbl[9]  = mk(0, 1, 0, 32'h101, 32'h0,        32'h0,        1, 0, 0, 0, 4'h0, 0, 1, 32'h0,        4'h0, 32'h0,        0, 32'h0);
    tbl[10] = mk(1, 2, 0, 32'h102, 32'h11223344, 32'h0,        1, 0, 0, 0, 4'h0, 0, 1, 32'h0,        4'h0, 32'h0,        0, 32'h0);
    tbl[11] = mk(0, 2, 0, 32'h108, 32'h0,        32'h55555555, 2, 1, 0, 0, 4'h0, 1, 1, 32'h0,        4'hF, 32'h0,        0, 32'h108);
    tbl[12] = mk(0, 2, 0, 32'h10C, 32'h0,        32'h66666666, 1, 2, 0, 0, 4'h0, 1, 1, 32'h0,        4'hF, 32'h0,        0, 32'h10C);
    tbl[13] = mk(1, 2, 0, 32'h110, 32'h12345678, 32'h0,        1, 1, 0, 0, 4'h0, 1, 0, 32'h0,        4'hF, 32'h12345678, 1, 32'h110);
    tbl[14] = mk(0, 0, 0, 32'h100, 32'h0,        32'h0000007F, 1, 0, 0, 0, 4'h0, 1, 0, 32'h0000007F, 4'h1, 32'h0,        0, 32'h100);
    tbl[15] = mk(0, 1, 0, 32'h100, 32'h0,        32'h00008000, 1, 0, 0, 0, 4'h0, 1, 0, 32'hFFFF8000, 4'h3, 32'h0,        0, 32'h100);

    // reset state
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_st_err", st_err_o, 0);
    chk("rst_sb_empty", sb_empty_o, 1);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_data", data_o, 0);
    @(negedge clk); rst_i = 0;
    tick();

    for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

    // fill the buffer with the bus stalled; the extra store waits for a pop
    begin
      bit seen = 0;
      int n = 0, guard = 0;
      bit prev = 0;
      for (int k = 0; k < DEP; k++)
        issue_store(32'h200 + 32'(4 * k), 32'(k + 1), $sformatf("fill%0d_valid", k));
      req_i = 1; we_i = 1; size_i = 2'b10; addr_i = 32'h210; data_i = 32'h55;
      repeat (6) begin
        tick();
        if (valid_o) seen = 1;
      end
      chk("full_stall", seen, 0);
      chk("full_cyc", wb_cyc_o, 1);
      chk("full_head_adr", wb_adr_o, 32'h200);
      chk("full_head_dat", wb_dat_o, 32'h1);
      wb_ack_i = 1;
      tick();
      wb_ack_i = 0;
      chk("full_nobypass", valid_o, 0);
      tick();
      chk("full_accept", valid_o, 1);
      req_i = 0;
      while (!(sb_empty_o && !wb_cyc_o) && guard < 100) begin
        if (wb_cyc_o && !prev) n++;
        prev = wb_cyc_o;
        wb_ack_i = wb_cyc_o;
        tick();
        guard++;
      end
      wb_ack_i = 0;
      chk("full_drain_done", guard < 100, 1);
      chk("full_drain_count", n, DEP);
    end

    // load with no response runs into the timeout
    begin
      bit got = 0;
      int cnt = 0;
      logic e = 0, cv = 1;
      logic [31:0] d = 32'hX;
      req_i = 1; we_i = 0; size_i = 2'b10; unsigned_i = 0; addr_i = 32'h300;
      for (int c = 0; c < TMO + 10 && !got; c++) begin
        tick();
        if (valid_o) begin got = 1; e = err_o; d = data_o; cv = wb_cyc_o; end
        else if (wb_cyc_o) cnt++;
      end
      req_i = 0;
      chk("tmo_valid", got, 1);
      chk("tmo_err", e, 1);
      chk("tmo_data", d, 0);
      chk("tmo_cyc_cycles", cnt, TMO);
      chk("tmo_cyc_dropped", cv, 0);
      tick();
    end

    // reset while a store is on the bus with more buffered
    begin
      bit bad = 0;
      for (int k = 0; k < 3; k++)
        issue_store(32'h400 + 32'(4 * k), 32'hA0 + 32'(k), $sformatf("rstfill%0d_valid", k));
      tick(); tick();
      chk("rst_mid_pre_cyc", wb_cyc_o, 1);
      #2 rst_i = 1;
      #1;
      chk("rst_mid_cyc", wb_cyc_o, 0);
      chk("rst_mid_sb_empty", sb_empty_o, 1);
      chk("rst_mid_valid", valid_o, 0);
      @(negedge clk); rst_i = 0;
      repeat (6) begin
        tick();
        if (wb_cyc_o || valid_o || !sb_empty_o) bad = 1;
      end
      chk("rst_mid_quiet", bad, 0);
    end

    chk("stb_eq_cyc", stb_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
